// File: rtl/adc_channel_avg.sv
// Eight-channel ADC block averager: 2^AVG_LOG2 samples per channel, valid/ready result port,
// per-channel average bank with registered readout. Optional min/max tracking under ADC_AVG_MINMAX_EN.
module adc_channel_avg #(
   parameter int AVG_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sample_valid,
   input  logic [11:0] sample_data,
   input  logic [2:0]  sample_ch,
   input  logic        clear,
   output logic        avg_valid,
   input  logic        avg_ready,
   output logic [11:0] avg_data,
   output logic [2:0]  avg_ch,
   output logic        overrun,
   input  logic [2:0]  rd_ch,
   output logic [11:0] rd_avg,
   output logic [11:0] rd_min,
   output logic [11:0] rd_max
);
   localparam int AW  = 12 + AVG_LOG2;
   localparam int NCH = 8;

   logic          accept, last, done;
   logic [AW-1:0] acc_q [NCH];
   logic [AW-1:0] sum;
   logic [11:0]   result;
   logic [11:0]   bank_q [NCH];
   logic [11:0]   rd_avg_q;
   logic          avg_valid_q, avg_valid_d;
   logic          overrun_q, overrun_d;
   logic [11:0]   avg_data_q, avg_data_d;
   logic [2:0]    avg_ch_q, avg_ch_d;

   // clear takes priority over a coincident sample, which is dropped
   assign accept = sample_valid && !clear;
   assign sum    = acc_q[sample_ch] + AW'(sample_data);
   assign result = 12'(sum >> AVG_LOG2);
   assign done   = accept && last;

   generate
      if (AVG_LOG2 > 0) begin : g_cnt
         logic [AVG_LOG2-1:0] cnt_q [NCH];
         assign last = (cnt_q[sample_ch] == '1);
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
            end else if (clear) begin
               for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
            end else if (accept) begin
               cnt_q[sample_ch] <= last ? '0 : cnt_q[sample_ch] + AVG_LOG2'(1);
            end
         end
      end else begin : g_nocnt
         assign last = 1'b1;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
      end else if (accept) begin
         acc_q[sample_ch] <= last ? '0 : sum;
      end
   end

   // A new result in the handshake cycle replaces the accepted one without flagging overrun
   always_comb begin
      avg_valid_d = avg_valid_q;
      overrun_d   = overrun_q;
      avg_data_d  = avg_data_q;
      avg_ch_d    = avg_ch_q;
      if (clear) begin
         avg_valid_d = 1'b0;
         overrun_d   = 1'b0;
      end else if (done) begin
         avg_valid_d = 1'b1;
         avg_data_d  = result;
         avg_ch_d    = sample_ch;
         if (avg_valid_q && !avg_ready) overrun_d = 1'b1;
      end else if (avg_valid_q && avg_ready) begin
         avg_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         avg_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         avg_data_q  <= '0;
         avg_ch_q    <= '0;
         rd_avg_q    <= '0;
         for (int i = 0; i < NCH; i++) bank_q[i] <= '0;
      end else begin
         avg_valid_q <= avg_valid_d;
         overrun_q   <= overrun_d;
         avg_data_q  <= avg_data_d;
         avg_ch_q    <= avg_ch_d;
         rd_avg_q    <= bank_q[rd_ch];
         if (done) bank_q[sample_ch] <= result;
      end
   end

   assign avg_valid = avg_valid_q;
   assign overrun   = overrun_q;
   assign avg_data  = avg_data_q;
   assign avg_ch    = avg_ch_q;
   assign rd_avg    = rd_avg_q;

`ifdef ADC_AVG_MINMAX_EN
   logic [11:0] min_q [NCH];
   logic [11:0] max_q [NCH];
   logic [11:0] rd_min_q, rd_max_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            min_q[i] <= 12'hFFF;
            max_q[i] <= 12'h000;
         end
         rd_min_q <= 12'hFFF;
         rd_max_q <= 12'h000;
      end else begin
         rd_min_q <= min_q[rd_ch];
         rd_max_q <= max_q[rd_ch];
         if (clear) begin
            for (int i = 0; i < NCH; i++) begin
               min_q[i] <= 12'hFFF;
               max_q[i] <= 12'h000;
            end
         end else if (accept) begin
            if (sample_data < min_q[sample_ch]) min_q[sample_ch] <= sample_data;
            if (sample_data > max_q[sample_ch]) max_q[sample_ch] <= sample_data;
         end
      end
   end

   assign rd_min = rd_min_q;
   assign rd_max = rd_max_q;
`else
   assign rd_min = 12'd0;
   assign rd_max = 12'd0;
`endif

endmodule
